// File: rtl/seg_pkg.sv
// seg_pkg: seven-segment patterns, symbol codes and digit-select masks shared by the 595 driver and receiver.
package seg_pkg;
  localparam int SEG_CODES = 19;
  localparam logic [4:0] SEG_BLANK = 5'd16;
  localparam logic [4:0] SEG_UNKNOWN = 5'd31;
  localparam logic [7:0] SEL_BLANK = 8'hff;
  typedef struct packed {
    logic [2:0] idx;
    logic [4:0] code;
    logic dot;
    logic en;
  } digit_t;
  function automatic logic [7:0] sel_mask(input logic [2:0] idx);
    return ~(8'h01 << idx);
  endfunction
  function automatic logic [6:0] seg_pattern(input logic [4:0] code);
    case (code)
      5'd0: return 7'h3f;
      5'd1: return 7'h06;
      5'd2: return 7'h5b;
      5'd3: return 7'h4f;
      5'd4: return 7'h66;
      5'd5: return 7'h6d;
      5'd6: return 7'h7d;
      5'd7: return 7'h07;
      5'd8: return 7'h7f;
      5'd9: return 7'h6f;
      5'd10: return 7'h46;
      5'd11: return 7'h70;
      5'd12: return 7'h40;
      5'd13: return 7'h76;
      5'd14: return 7'h49;
      5'd15: return 7'h79;
      5'd17: return 7'h73;
      5'd18: return 7'h48;
      default: return 7'h00;
    endcase
  endfunction
  function automatic logic [4:0] seg_code(input logic [6:0] pat);
    logic [4:0] code;
    code = SEG_UNKNOWN;
    for (int c = SEG_CODES - 1; c >= 0; c--) code = (seg_pattern(5'(c)) == pat) ? 5'(c) : code;
    return code;
  endfunction
endpackage

// File: rtl/hc595_sync_edge.sv
// hc595_sync_edge: multi-flop synchronizer for one asynchronous 595 line plus rising-edge detector.
module hc595_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic sync,
  output logic rise
);
  logic [SYNC_STAGES-1:0] stages;
  logic prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stages <= '0;
      prev <= 1'b0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], pin};
      prev <= stages[SYNC_STAGES-1];
    end
  assign sync = stages[SYNC_STAGES-1];
  assign rise = sync & ~prev;
endmodule

// File: rtl/hc595_seg_receiver.sv
// hc595_seg_receiver: rebuilds 16-bit 595 scan frames from SCK/SER/RCK and keeps an 8-digit display image.
module hc595_seg_receiver
  import seg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk_in,
  input  logic        sdio_in,
  input  logic        rclk_in,
  output logic        frame_valid,
  output logic [15:0] frame_data,
  output logic [2:0]  digit_idx,
  output logic [4:0]  digit_code,
  output logic        digit_dot,
  output logic        digit_en,
  output logic        seg_unknown,
  output logic        frame_err,
  output logic [39:0] disp_codes,
  output logic [7:0]  disp_dot,
  output logic [7:0]  disp_en
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic sck_rise, rck_rise, sdio_sync;
  logic sck_sync_unused, rck_sync_unused, sdio_rise_unused;
  logic [15:0] shreg, shreg_n;
  logic [4:0] bitcnt, bitcnt_n;
  logic [TW-1:0] timer;
  logic [2:0] slot;
  logic sel_ok, good, timeout;
  digit_t dig;
  hc595_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (.clk(clk), .rst_n(rst_n), .pin(sclk_in), .sync(sck_sync_unused), .rise(sck_rise));
  hc595_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sdio (.clk(clk), .rst_n(rst_n), .pin(sdio_in), .sync(sdio_sync), .rise(sdio_rise_unused));
  hc595_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_rck (.clk(clk), .rst_n(rst_n), .pin(rclk_in), .sync(rck_sync_unused), .rise(rck_rise));
  // A same-cycle SCK rise is folded in before the RCK check looks at the frame.
  always_comb begin
    shreg_n = sck_rise ? {shreg[14:0], sdio_sync} : shreg;
    bitcnt_n = !sck_rise ? bitcnt : (bitcnt == 5'd17) ? bitcnt : bitcnt + 5'd1;
    timeout = (bitcnt != 5'd0) && !sck_rise && !rck_rise && (timer == TW'(TIMEOUT_CYCLES - 1));
  end
  always_comb begin
    sel_ok = shreg_n[7:0] == SEL_BLANK;
    dig.idx = slot;
    dig.code = seg_code(shreg_n[14:8]);
    dig.dot = shreg_n[15];
    dig.en = shreg_n[7:0] != SEL_BLANK;
    for (int k = 0; k < 8; k++) begin
      sel_ok = (shreg_n[7:0] == sel_mask(3'(k))) ? 1'b1 : sel_ok;
      dig.idx = (shreg_n[7:0] == sel_mask(3'(k))) ? 3'(k) : dig.idx;
    end
  end
  assign good = rck_rise && (bitcnt_n == 5'd16) && sel_ok;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frame_valid <= 1'b0;
      frame_err <= 1'b0;
      seg_unknown <= 1'b0;
      frame_data <= '0;
      digit_idx <= '0;
      digit_code <= '0;
      digit_dot <= 1'b0;
      digit_en <= 1'b0;
      disp_codes <= {8{SEG_BLANK}};
      disp_dot <= '0;
      disp_en <= '0;
      shreg <= '0;
      bitcnt <= '0;
      timer <= '0;
      slot <= '0;
    end else begin
      frame_valid <= good;
      frame_err <= (rck_rise && !good) || timeout;
      seg_unknown <= good && (dig.code == SEG_UNKNOWN);
      shreg <= shreg_n;
      bitcnt <= (rck_rise || timeout) ? 5'd0 : bitcnt_n;
      timer <= (sck_rise || rck_rise || timeout || bitcnt == 5'd0) ? '0 : timer + 1'b1;
      if (good) begin
        frame_data <= shreg_n;
        digit_idx <= dig.idx;
        digit_code <= dig.code;
        digit_dot <= dig.dot;
        digit_en <= dig.en;
        slot <= dig.idx + 3'd1;
        disp_codes[5*dig.idx +: 5] <= dig.code;
        disp_dot[dig.idx] <= dig.dot;
        disp_en[dig.idx] <= dig.en;
      end
    end
endmodule

// File: tb/tb_hc595_seg_receiver.sv
// tb_hc595_seg_receiver: directed 595 frames; expected pulses queued at issue time, checked by a separate monitor.
module tb_hc595_seg_receiver;
  logic clk = 1'b0, rst_n = 1'b0, sclk_in = 1'b0, sdio_in = 1'b0, rclk_in = 1'b0;
  logic frame_valid, digit_dot, digit_en, seg_unknown, frame_err;
  logic [15:0] frame_data;
  logic [2:0] digit_idx;
  logic [4:0] digit_code;
  logic [39:0] disp_codes;
  logic [7:0] disp_dot, disp_en;
  int checks = 0, errors = 0;
  typedef struct {
    bit ok;
    logic [15:0] data;
    logic [2:0] idx;
    logic [4:0] code;
    logic dot, en, unk;
    logic [39:0] codes;
    logic [7:0] dots, ens;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [39:0] m_codes = {8{5'd16}};
  logic [7:0] m_dots = '0, m_ens = '0;

  hc595_seg_receiver #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .sclk_in(sclk_in), .sdio_in(sdio_in), .rclk_in(rclk_in),
    .frame_valid(frame_valid), .frame_data(frame_data), .digit_idx(digit_idx), .digit_code(digit_code),
    .digit_dot(digit_dot), .digit_en(digit_en), .seg_unknown(seg_unknown), .frame_err(frame_err),
    .disp_codes(disp_codes), .disp_dot(disp_dot), .disp_en(disp_en)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_good(input logic [15:0] data, input logic [2:0] idx, input logic [4:0] code,
                             input logic dot, input logic en, input logic unk);
    m_codes[5*idx +: 5] = code;
    m_dots[idx] = dot;
    m_ens[idx] = en;
    q.push_back('{1'b1, data, idx, code, dot, en, unk, m_codes, m_dots, m_ens});
  endtask

  task automatic expect_err();
    q.push_back('{1'b0, 16'h0, 3'h0, 5'h0, 1'b0, 1'b0, 1'b0, m_codes, m_dots, m_ens});
  endtask

  task automatic sck_bit(input logic b);
    sdio_in = b;
    repeat (3) @(posedge clk);
    #1 sclk_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 sclk_in = 1'b0;
  endtask

  task automatic send(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) sck_bit(v[15 - (i % 16)]);
  endtask

  task automatic rck_pulse();
    repeat (3) @(posedge clk);
    #1 rclk_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rclk_in = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    chk("rst_valid", frame_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_data", frame_data, 0);
    chk("rst_digit", {digit_idx, digit_code, digit_dot, digit_en}, 0);
    chk("rst_codes", disp_codes, {8{5'd16}});
    chk("rst_dot_en", {disp_dot, disp_en}, 0);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (seg_unknown && !frame_valid) chk("unk_alone", seg_unknown, 0);
    if (frame_valid || frame_err) begin
      chk("exclusive", frame_valid & frame_err, 0);
      if (q.size() == 0) chk("unexpected_pulse", {frame_valid, frame_err}, 0);
      else begin
        e = q.pop_front();
        chk("kind_valid", frame_valid, e.ok);
        if (e.ok) begin
          chk("frame_data", frame_data, e.data);
          chk("digit_idx", digit_idx, e.idx);
          chk("digit_code", digit_code, e.code);
          chk("digit_dot", digit_dot, e.dot);
          chk("digit_en", digit_en, e.en);
        end
        chk("seg_unknown", seg_unknown, e.unk);
        chk("disp_codes", disp_codes, e.codes);
        chk("disp_dot", disp_dot, e.dots);
        chk("disp_en", disp_en, e.ens);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_state();
    expect_good(16'h06FE, 3'd0, 5'd1, 1'b0, 1'b1, 1'b0);
    send(16'h06FE, 16); rck_pulse();
    expect_good(16'hBF7F, 3'd7, 5'd0, 1'b1, 1'b1, 1'b0);
    send(16'hBF7F, 16); rck_pulse();
    expect_good(16'h00FF, 3'd0, 5'd16, 1'b0, 1'b0, 1'b0);
    send(16'h00FF, 16); rck_pulse();
    expect_good(16'h5BFD, 3'd1, 5'd2, 1'b0, 1'b1, 1'b0);
    send(16'h5BFD, 16); rck_pulse();
    expect_good(16'h00FF, 3'd2, 5'd16, 1'b0, 1'b0, 1'b0);
    send(16'h00FF, 16); rck_pulse();
    expect_err();
    send(16'h4FF7, 15); rck_pulse();
    expect_err();
    send(16'h3FFC, 16); rck_pulse();
    expect_good(16'h80FF, 3'd3, 5'd16, 1'b1, 1'b0, 1'b0);
    send(16'h80FF, 16); rck_pulse();
    expect_good(16'h1FEF, 3'd4, 5'd31, 1'b0, 1'b1, 1'b1);
    send(16'h1FEF, 16); rck_pulse();
    expect_err();
    send(16'h6D00, 8); repeat (100) @(posedge clk);
    expect_good(16'h4FF7, 3'd3, 5'd3, 1'b0, 1'b1, 1'b0);
    send(16'h4FF7, 16); rck_pulse();
    expect_err();
    send(16'h06FE, 17); rck_pulse();
    send(16'h7DFB, 8);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_codes = {8{5'd16}}; m_dots = '0; m_ens = '0;
    check_reset_state();
    expect_err();
    send(16'h7DFB, 8); rck_pulse();
    expect_good(16'h7DFB, 3'd2, 5'd6, 1'b0, 1'b1, 1'b0);
    send(16'h7DFB, 16); rck_pulse();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
